// File: rtl/mult_ctrl_if.sv
// Strobe and button bundle between the multiplier control unit and the A/B/X datapath.
// The master side is the control unit. The slave side is the datapath, which also
// forwards the synchronized buttons.
interface mult_ctrl_if;
  logic clear_a_load_b;  // active-low, synchronized
  logic run;             // active-low, synchronized
  logic m;               // B[0] from the datapath
  logic ld_b;
  logic clr_ax;
  logic add_en;
  logic sub_en;
  logic shift_en;
  logic busy;
  logic done;

  modport master (
    input  clear_a_load_b,
    input  run,
    input  m,
    output ld_b,
    output clr_ax,
    output add_en,
    output sub_en,
    output shift_en,
    output busy,
    output done
  );

  modport slave (
    output clear_a_load_b,
    output run,
    output m,
    input  ld_b,
    input  clr_ax,
    input  add_en,
    input  sub_en,
    input  shift_en,
    input  busy,
    input  done
  );
endinterface

// File: rtl/mult_ctrl.sv
// Control unit for the 8x8 signed shift-add multiplier.
// It turns the button levels into one-hot datapath strobes.
// Each multiply runs CLRAX, then 8 x (ADD, SHIFT), then waits in HOLD until run is released.
module mult_ctrl (
  input  logic        Clk,
  input  logic        reset,
  mult_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    StIdle,
    StLoadB,
    StClrAx,
    StAdd,
    StShift,
    StHold
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       run_prev_q;
  logic       run_fall;

  // A press is the falling edge of the active-low run level.
  assign run_fall = ~bus.run & run_prev_q;

  // State, iteration counter and run history.
  // run history updates every cycle, so presses made while busy are not replayed.
  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 3'd0;
      run_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      run_prev_q <= bus.run;
    end
  end

  // Next-state logic and Moore strobe decode; add/sub are further qualified by m.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    bus.ld_b     = 1'b0;
    bus.clr_ax   = 1'b0;
    bus.add_en   = 1'b0;
    bus.sub_en   = 1'b0;
    bus.shift_en = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;

    unique case (state_q)
      StIdle: begin
        // run wins over clear_a_load_b when both occur in the same cycle
        if (run_fall) begin
          state_d = StClrAx;
        end else if (!bus.clear_a_load_b) begin
          state_d = StLoadB;
        end
      end
      StLoadB: begin
        bus.ld_b = 1'b1;
        state_d  = StIdle;
      end
      StClrAx: begin
        bus.clr_ax = 1'b1;
        bus.busy   = 1'b1;
        cnt_d      = 3'd0;
        state_d    = StAdd;
      end
      StAdd: begin
        bus.busy = 1'b1;
        // The last partial product has negative weight, which is the sign correction.
        if (bus.m) begin
          if (cnt_q == 3'd7) begin
            bus.sub_en = 1'b1;
          end else begin
            bus.add_en = 1'b1;
          end
        end
        state_d = StShift;
      end
      StShift: begin
        bus.shift_en = 1'b1;
        bus.busy     = 1'b1;
        if (cnt_q == 3'd7) begin
          state_d = StHold;
        end else begin
          cnt_d   = cnt_q + 3'd1;
          state_d = StAdd;
        end
      end
      StHold: begin
        bus.done = 1'b1;
        if (bus.run) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_ctrl.sv
// Bench for mult_ctrl. It wraps the controller in a small A/B/X datapath and checks
// strobe counts, latency and the final product against constant expectations.
module tb_mult_ctrl;

  logic Clk = 1'b0;
  logic reset;

  // 50 MHz
  always #10 Clk = ~Clk;

  mult_ctrl_if bus ();

  mult_ctrl dut (
    .Clk  (Clk),
    .reset(reset),
    .bus  (bus)
  );

  // Datapath around the controller
  logic [7:0] s_val = 8'h00;
  logic [7:0] a_q   = 8'h00;
  logic [7:0] b_q   = 8'h00;
  logic       x_q   = 1'b0;
  logic       m_tie_en;
  logic       m_tie_val;

  assign bus.m = m_tie_en ? m_tie_val : b_q[0];

  always @(posedge Clk) begin
    if (bus.ld_b) begin
      b_q <= s_val;
      a_q <= 8'h00;
      x_q <= 1'b0;
    end else if (bus.clr_ax) begin
      a_q <= 8'h00;
      x_q <= 1'b0;
    end else if (bus.add_en) begin
      {x_q, a_q} <= {x_q, a_q} + {s_val[7], s_val};
    end else if (bus.sub_en) begin
      {x_q, a_q} <= {x_q, a_q} - {s_val[7], s_val};
    end else if (bus.shift_en) begin
      a_q <= {x_q, a_q[7:1]};
      b_q <= {a_q[0], b_q[7:1]};
    end
  end

  typedef struct {
    logic [15:0] prod;
    logic        x;
    int          adds;
    int          subs;
    bit          chk_prod;
  } exp_t;

  typedef struct {
    logic [7:0]  b;
    logic [7:0]  s;
    logic [15:0] prod;
    logic        x;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {bus.ld_b, bus.clr_ax, bus.add_en, bus.sub_en, bus.shift_en, bus.busy, bus.done};
  endfunction

  // Load bv into B, then press run with sv on S.
  // abort_at > 0 asserts reset at that cycle of the multiply.
  // hold_extra keeps run low in HOLD for that many extra cycles.
  // clr_busy holds clear_a_load_b low from the press until release.
  task automatic run_mult(input logic [7:0] bv, input logic [7:0] sv, input logic [15:0] prod,
                          input logic x, input bit chk_prod, input int abort_at,
                          input int hold_extra, input bit clr_busy);
    exp_t e;
    int   adds = 0, subs = 0, shifts = 0, busy_n = 0, ld_n = 0, multi = 0, done_at = 0;
    int   hold_lost = 0, hold_busy = 0;

    s_val = bv;
    bus.clear_a_load_b = 1'b0;
    step();
    bus.clear_a_load_b = 1'b1;
    step();
    s_val = sv;

    e.prod     = prod;
    e.x        = x;
    e.chk_prod = chk_prod;
    if (m_tie_en) begin
      e.adds = m_tie_val ? 7 : 0;
      e.subs = m_tie_val ? 1 : 0;
    end else begin
      e.adds = $countones(bv[6:0]);
      e.subs = bv[7] ? 1 : 0;
    end
    sb.push_back(e);

    bus.run = 1'b0;
    if (clr_busy) bus.clear_a_load_b = 1'b0;

    for (int i = 1; i <= 40 && done_at == 0; i++) begin
      step();
      if (bus.ld_b) ld_n++;
      if (bus.add_en) adds++;
      if (bus.sub_en) subs++;
      if (bus.shift_en) shifts++;
      if (bus.busy) busy_n++;
      if ($countones({bus.ld_b, bus.clr_ax, bus.add_en, bus.sub_en, bus.shift_en}) > 1) multi++;
      if (i == 1) check("clrax_after_press", {bus.clr_ax, bus.busy}, 2'b11);
      if (abort_at != 0 && i == abort_at) begin
        check("abort_point_shift", bus.shift_en, 1'b1);
        reset = 1'b1;
        bus.run = 1'b1;
        bus.clear_a_load_b = 1'b1;
        step();
        check("abort_outs_zero", outs(), 7'd0);
        reset = 1'b0;
        step();
        check("abort_idle_outs", outs(), 7'd0);
        void'(sb.pop_back());
        return;
      end
      if (bus.done) done_at = i;
    end

    check("done_latency", done_at, 18);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("add_count", adds, e.adds);
      check("sub_count", subs, e.subs);
      check("shift_count", shifts, 8);
      check("busy_cycles", busy_n, 17);
      check("strobe_onehot", multi, 0);
      if (e.chk_prod) begin
        check("product_ab", {a_q, b_q}, e.prod);
        check("product_x", x_q, e.x);
      end
    end else begin
      check("scoreboard_empty", sb.size(), 1);
    end

    for (int i = 0; i < hold_extra; i++) begin
      step();
      if (!bus.done) hold_lost++;
      if (bus.busy || bus.clr_ax || bus.shift_en) hold_busy++;
      if (bus.ld_b) ld_n++;
    end
    if (hold_extra > 0) begin
      check("hold_done_kept", hold_lost, 0);
      check("hold_no_restart", hold_busy, 0);
    end
    if (clr_busy) check("no_ld_while_busy", ld_n, 0);

    bus.run = 1'b1;
    bus.clear_a_load_b = 1'b1;
    step();
    check("release_to_idle", outs(), 7'd0);
    step();
  endtask

  vec_t      vecs[8];
  logic [2:0] pat3;
  logic [5:0] pat6;
  logic       busy_seen;

  initial begin
    vecs[0] = '{8'hC5, 8'h07, 16'hFE63, 1'b1};  // -59 * 7
    vecs[1] = '{8'h07, 8'hC5, 16'hFE63, 1'b1};  // 7 * -59
    vecs[2] = '{8'h80, 8'h80, 16'h4000, 1'b0};  // -128 * -128
    vecs[3] = '{8'h00, 8'h55, 16'h0000, 1'b0};
    vecs[4] = '{8'hFF, 8'hFF, 16'h0001, 1'b0};  // -1 * -1
    vecs[5] = '{8'h7F, 8'h7F, 16'h3F01, 1'b0};  // 127 * 127
    vecs[6] = '{8'h80, 8'h7F, 16'hC080, 1'b1};  // -128 * 127
    vecs[7] = '{8'h01, 8'h80, 16'hFF80, 1'b1};  // 1 * -128

    reset = 1'b1;
    bus.run = 1'b1;
    bus.clear_a_load_b = 1'b1;
    m_tie_en = 1'b0;
    m_tie_val = 1'b0;
    step();
    step();
    check("reset_outs", outs(), 7'd0);
    reset = 1'b0;
    step();
    check("idle_outs", outs(), 7'd0);

    // Single-cycle clear_a_load_b pulse
    bus.clear_a_load_b = 1'b0;
    step();
    pat3[2] = bus.ld_b;
    bus.clear_a_load_b = 1'b1;
    step();
    pat3[1] = bus.ld_b;
    step();
    pat3[0] = bus.ld_b;
    check("ld_pulse_once", pat3, 3'b100);

    // clear_a_load_b held low for six cycles
    bus.clear_a_load_b = 1'b0;
    pat6 = '0;
    busy_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      pat6 = {pat6[4:0], bus.ld_b};
      busy_seen = busy_seen | bus.busy;
    end
    bus.clear_a_load_b = 1'b1;
    check("ld_held_pattern", pat6, 6'b101010);
    check("ld_held_not_busy", busy_seen, 1'b0);
    step();

    for (int i = 0; i < 8; i++) begin
      run_mult(vecs[i].b, vecs[i].s, vecs[i].prod, vecs[i].x, 1'b1, 0, 0, 1'b0);
    end

    // m tied high, then tied low
    m_tie_en = 1'b1;
    m_tie_val = 1'b1;
    run_mult(8'h00, 8'h11, 16'h0000, 1'b0, 1'b0, 0, 0, 1'b0);
    m_tie_val = 1'b0;
    run_mult(8'hFF, 8'h11, 16'h0000, 1'b0, 1'b0, 0, 0, 1'b0);
    m_tie_en = 1'b0;

    // Reset in the SHIFT cycle with cnt = 3, then a fresh full multiply
    run_mult(8'h12, 8'h34, 16'h0000, 1'b0, 1'b1, 9, 0, 1'b0);
    run_mult(vecs[0].b, vecs[0].s, vecs[0].prod, vecs[0].x, 1'b1, 0, 0, 1'b0);

    // Run held through HOLD with clear_a_load_b pressed while busy, then a second multiply
    run_mult(vecs[1].b, vecs[1].s, vecs[1].prod, vecs[1].x, 1'b1, 0, 20, 1'b1);
    run_mult(vecs[2].b, vecs[2].s, vecs[2].prod, vecs[2].x, 1'b1, 0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
